// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM behind a load/store request port with a DataDone pulse.
// Latency WAIT_CYCLES+1 cycles from acceptance to DataDone; requests arriving while Busy are dropped and flagged.
module data_mem_responder #(
    parameter int WORD_SIZE   = 16,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [WORD_SIZE-1:0] DataAddr,
    input  logic [WORD_SIZE-1:0] DataOut,
    input  logic                 ReadData,
    input  logic                 WriteData,
    output logic [WORD_SIZE-1:0] DataIn,
    output logic                 DataDone,
    output logic                 Busy,
    output logic                 Overrun,
    output logic                 AddrErr
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t               state;
    state_t               next_state;
    logic [3:0]           cnt;
    logic [WORD_SIZE-1:0] mem [DEPTH];
    logic [WORD_SIZE-1:0] hold;
    logic                 rd_pend;
    logic [WORD_SIZE-1:0] data_in_q;
    logic                 overrun_q;
    logic                 addr_err_q;

    logic                 req;
    logic                 accept;
    logic                 addr_ok;
    logic [AW-1:0]        mem_idx;
    logic [WORD_SIZE-1:0] rd_val;
    logic                 wait_last;

    assign req       = ReadData | WriteData;
    assign accept    = req && (state != S_WAIT);
    assign addr_ok   = 32'(DataAddr) < DEPTH;
    assign mem_idx   = DataAddr[AW-1:0];
    assign wait_last = (state == S_WAIT) && (cnt == 4'd1);

    // Out-of-range reads return 0; a combined read/write returns the store data.
    always_comb begin
        rd_val = '0;
        if (addr_ok) begin
            rd_val = WriteData ? DataOut : mem[mem_idx];
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (req) begin
                    next_state = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
                end else begin
                    next_state = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd1) begin
                    next_state = S_DONE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        DataDone = 1'b0;
        Busy     = 1'b0;
        DataIn   = data_in_q;
        Overrun  = overrun_q;
        AddrErr  = addr_err_q;
        if (state == S_DONE) begin
            DataDone = 1'b1;
        end
        if (state == S_WAIT) begin
            Busy = 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= WAIT_INIT;
        end else if (state == S_WAIT) begin
            cnt <= cnt - 4'd1;
        end
    end

    // RAM is deliberately left out of reset so committed stores survive it.
    always_ff @(posedge Clock) begin
        if (!Reset && accept && WriteData && addr_ok) begin
            mem[mem_idx] <= DataOut;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            hold       <= '0;
            rd_pend    <= 1'b0;
            data_in_q  <= '0;
            overrun_q  <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            if (accept) begin
                hold    <= rd_val;
                rd_pend <= ReadData;
                if ((WAIT_CYCLES == 0) && ReadData) begin
                    data_in_q <= rd_val;
                end
            end
            if (wait_last && rd_pend) begin
                data_in_q <= hold;
            end
            if (req && (state == S_WAIT)) begin
                overrun_q <= 1'b1;
            end
            if (accept && !addr_ok) begin
                addr_err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: vector table at W=0, wait-state and reset sequences, random stream vs. model.
module tb_data_mem_responder;

    logic        Clock;
    logic        Reset;
    logic [15:0] DataAddr;
    logic [15:0] DataOut;
    logic        ReadData;
    logic        WriteData;

    logic [15:0] din0, din2, din3;
    logic        done0, done2, done3;
    logic        busy0, busy2, busy3;
    logic        ovr0, ovr2, ovr3;
    logic        aerr0, aerr2, aerr3;

    int checks = 0;
    int failures = 0;

    data_mem_responder #(.WORD_SIZE(16), .DEPTH(256), .WAIT_CYCLES(0)) dut0 (
        .Clock(Clock), .Reset(Reset), .DataAddr(DataAddr), .DataOut(DataOut),
        .ReadData(ReadData), .WriteData(WriteData), .DataIn(din0), .DataDone(done0),
        .Busy(busy0), .Overrun(ovr0), .AddrErr(aerr0)
    );
    data_mem_responder #(.WORD_SIZE(16), .DEPTH(256), .WAIT_CYCLES(2)) dut2 (
        .Clock(Clock), .Reset(Reset), .DataAddr(DataAddr), .DataOut(DataOut),
        .ReadData(ReadData), .WriteData(WriteData), .DataIn(din2), .DataDone(done2),
        .Busy(busy2), .Overrun(ovr2), .AddrErr(aerr2)
    );
    data_mem_responder #(.WORD_SIZE(16), .DEPTH(256), .WAIT_CYCLES(3)) dut3 (
        .Clock(Clock), .Reset(Reset), .DataAddr(DataAddr), .DataOut(DataOut),
        .ReadData(ReadData), .WriteData(WriteData), .DataIn(din3), .DataDone(done3),
        .Busy(busy3), .Overrun(ovr3), .AddrErr(aerr3)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] dout;
        logic        done;
        logic [15:0] din;
        logic        aerr;
    } vec_t;

    vec_t        vecs [10];
    logic [15:0] ref_mem [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are read at the next falling edge.
    task automatic tick(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
        Reset     = 1'b0;
        ReadData  = rd;
        WriteData = wr;
        DataAddr  = a;
        DataOut   = d;
        @(negedge Clock);
    endtask

    task automatic rst_tick();
        Reset     = 1'b1;
        ReadData  = 1'b0;
        WriteData = 1'b0;
        DataAddr  = '0;
        DataOut   = '0;
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    initial begin
        logic [15:0] exp_din;
        logic        exp_aerr;
        logic [15:0] a;
        logic [15:0] d;
        int          kind;

        vecs[0] = '{1'b0, 1'b1, 16'd5,   16'hBEEF, 1'b1, 16'h0000, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 16'd5,   16'h0000, 1'b1, 16'hBEEF, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 16'd0,   16'h0000, 1'b0, 16'hBEEF, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 16'd9,   16'h00AA, 1'b1, 16'h00AA, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 16'd0,   16'h0000, 1'b0, 16'h00AA, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 16'd9,   16'h0000, 1'b1, 16'h00AA, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 16'd0,   16'h1111, 1'b1, 16'h00AA, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 16'd256, 16'h5555, 1'b1, 16'h00AA, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 16'd256, 16'h0000, 1'b1, 16'h0000, 1'b1};
        vecs[9] = '{1'b1, 1'b0, 16'd0,   16'h0000, 1'b1, 16'h1111, 1'b1};

        Reset = 1'b1; ReadData = 1'b0; WriteData = 1'b0; DataAddr = '0; DataOut = '0;
        @(negedge Clock);
        rst_tick();
        chk("reset_din",   32'(din0), 32'h0);
        chk("reset_done",  32'(done0), 32'h0);
        chk("reset_busy",  32'(busy3), 32'h0);
        chk("reset_ovr",   32'(ovr0), 32'h0);
        chk("reset_aerr",  32'(aerr0), 32'h0);

        for (int i = 0; i < 10; i++) begin
            tick(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].dout);
            chk($sformatf("vec%0d_done", i), 32'(done0), 32'(vecs[i].done));
            chk($sformatf("vec%0d_din", i),  32'(din0),  32'(vecs[i].din));
            chk($sformatf("vec%0d_aerr", i), 32'(aerr0), 32'(vecs[i].aerr));
        end
        chk("vec_ovr", 32'(ovr0), 32'h0);

        // Three wait states, with a second read dropped mid-wait.
        rst_tick();
        tick(1'b0, 1'b1, 16'd7, 16'h1234);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 16'd0, 16'd0);
        chk("w3_ovr_before", 32'(ovr3), 32'h0);
        tick(1'b1, 1'b0, 16'd7, 16'd0);
        chk("w3_busy1", 32'(busy3), 32'h1);
        chk("w3_done1", 32'(done3), 32'h0);
        tick(1'b0, 1'b0, 16'd0, 16'd0);
        chk("w3_busy2", 32'(busy3), 32'h1);
        tick(1'b1, 1'b0, 16'd8, 16'd0);
        chk("w3_busy3", 32'(busy3), 32'h1);
        chk("w3_ovr",   32'(ovr3), 32'h1);
        chk("w3_din_pending", 32'(din3), 32'h0);
        tick(1'b0, 1'b0, 16'd0, 16'd0);
        chk("w3_done",  32'(done3), 32'h1);
        chk("w3_busy_done", 32'(busy3), 32'h0);
        chk("w3_din",   32'(din3), 32'h1234);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 16'd0, 16'd0);
            chk("w3_single_done", 32'(done3), 32'h0);
            chk("w3_din_held", 32'(din3), 32'h1234);
        end

        // Reset during a two-wait-state read.
        rst_tick();
        tick(1'b0, 1'b1, 16'd20, 16'hABCD);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 16'd0, 16'd0);
        tick(1'b1, 1'b0, 16'd20, 16'd0);
        chk("w2_busy", 32'(busy2), 32'h1);
        rst_tick();
        chk("w2_rst_din",  32'(din2), 32'h0);
        chk("w2_rst_done", 32'(done2), 32'h0);
        chk("w2_rst_busy", 32'(busy2), 32'h0);
        chk("w2_rst_ovr",  32'(ovr2), 32'h0);
        chk("w2_rst_aerr", 32'(aerr2), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 16'd0, 16'd0);
            chk("w2_no_done", 32'(done2), 32'h0);
        end
        tick(1'b1, 1'b0, 16'd20, 16'd0);
        tick(1'b0, 1'b0, 16'd0, 16'd0);
        chk("w2_not_yet", 32'(done2), 32'h0);
        tick(1'b0, 1'b0, 16'd0, 16'd0);
        chk("w2_done", 32'(done2), 32'h1);
        chk("w2_din",  32'(din2), 32'hABCD);

        // Random back-to-back stream at zero wait states.
        rst_tick();
        for (int i = 0; i < 32; i++) begin
            d = 16'($urandom);
            ref_mem[i] = d;
            tick(1'b0, 1'b1, 16'(i), d);
        end
        exp_din  = 16'h0;
        exp_aerr = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            kind = int'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) a = 16'(256 + $urandom_range(0, 1000));
            else a = 16'($urandom_range(0, 31));
            d = 16'($urandom);
            if (a >= 16'd256) begin
                exp_aerr = 1'b1;
                if (kind != 1) exp_din = 16'h0;
            end else begin
                if (kind == 0) exp_din = ref_mem[a[4:0]];
                if (kind == 2) exp_din = d;
                if (kind != 0) ref_mem[a[4:0]] = d;
            end
            tick(kind != 1, kind != 0, a, d);
            chk("rand_din",  32'(din0), 32'(exp_din));
            chk("rand_done", 32'(done0), 32'h1);
        end
        chk("rand_ovr",  32'(ovr0), 32'h0);
        chk("rand_aerr", 32'(aerr0), 32'(exp_aerr));
        for (int i = 0; i < 32; i++) begin
            tick(1'b1, 1'b0, 16'(i), 16'd0);
            chk("rand_final_mem", 32'(din0), 32'(ref_mem[i]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
